uart_byte_tx: RTL and testbench



---
 rtl/uart_tx_pkg.sv | 18 +
 rtl/uart_byte_tx_if.sv | 20 ++
 rtl/baud_tick_gen.sv | 37 +++
 rtl/uart_byte_tx.sv | 136 +++++++++++++
 tb/tb_uart_byte_tx.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and line levels for the UART byte transmitter.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam int   DATA_BITS   = 8;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_byte_tx_if.sv
// Byte handshake between the upstream producer and the UART transmitter.
interface uart_byte_tx_if;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/baud_tick_gen.sv
// Baud divider: counts 0..CLKS_PER_BIT-1 and pulses tick on the terminal count.
// clear holds the count at zero so every frame starts on a fresh bit period.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 87,
    parameter int CNT_W        = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign tick = !clear && (count_q == LAST_COUNT);

    // Next count: restart on clear or after the terminal count, otherwise advance.
    always_comb begin
        count_d = count_q + CNT_W'(1);
        if (clear || tick) begin
            count_d = '0;
        end
    end

    // Divider register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_byte_tx.sv
// UART byte transmitter: accepts a byte on a valid/ready handshake and sends it
// as an 8N1 frame, LSB first, on tx. Defining UART_TX_PARITY_EN inserts an
// even-parity bit between the data bits and the stop bit.
module uart_byte_tx
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int CNT_W        = 16
) (
    input  logic           clk,
    input  logic           rst,
    uart_byte_tx_if.slave  up,
    output logic           tx,
    output logic           busy
);

    tx_state_e              state_q, state_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q, parity_d;
`endif

    logic tick;
    logic accept;

    assign up.in_ready = (state_q == IDLE) && !rst;
    assign accept      = up.in_valid && up.in_ready;
    assign tx          = tx_q;
    assign busy        = busy_q;

    baud_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (state_q == IDLE),
        .tick  (tick)
    );

    // Frame sequencing: pick the next state and the next line level at each bit boundary.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        tx_d      = tx_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                tx_d = IDLE_LEVEL;
                if (accept) begin
                    state_d   = START;
                    shreg_d   = up.in_data;
                    bit_idx_d = '0;
                    tx_d      = START_LEVEL;
`ifdef UART_TX_PARITY_EN
                    parity_d  = ^up.in_data;
`endif
                end
            end
            START: begin
                if (tick) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    tx_d      = shreg_q[0];
                    shreg_d   = {1'b0, shreg_q[DATA_BITS-1:1]};
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = STOP_LEVEL;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shreg_q[0];
                        shreg_d   = {1'b0, shreg_q[DATA_BITS-1:1]};
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    tx_d    = STOP_LEVEL;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    tx_d    = IDLE_LEVEL;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = IDLE_LEVEL;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, shift register and registered outputs; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= IDLE_LEVEL;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Testbench for uart_byte_tx. The reference model tracks each frame as a list of
// line levels and a cycle count since acceptance. Honours UART_TX_PARITY_EN.
module tb_uart_byte_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx;
    logic busy;

    uart_byte_tx_if bus ();

    uart_byte_tx #(
        .CLKS_PER_BIT (CPB),
        .CNT_W        (8)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .up   (bus),
        .tx   (tx),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;

    int   m_left = 0;
    int   m_pos  = 0;
    logic frame_bits [FRAME_BITS];
    bit   acc_seen;
    int   n_accepts = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model over the edge, then compare outputs.
    task automatic applyStimulus(input logic r, input logic v, input logic [7:0] d);
        logic exp_tx;
        @(negedge clk);
        rst          = r;
        bus.in_valid = v;
        bus.in_data  = d;
        @(posedge clk);
        acc_seen = 1'b0;
        if (r) begin
            m_left = 0;
            m_pos  = 0;
        end else if (m_left == 0 && v) begin
            frame_bits[0] = 1'b0;
            for (int i = 0; i < 8; i++) frame_bits[i + 1] = d[i];
`ifdef UART_TX_PARITY_EN
            frame_bits[9]  = ^d;
            frame_bits[10] = 1'b1;
`else
            frame_bits[9]  = 1'b1;
`endif
            m_left   = FRAME_CYC;
            m_pos    = 0;
            acc_seen = 1'b1;
            n_accepts++;
        end else if (m_left > 0) begin
            m_left--;
            m_pos++;
        end
        #1;
        exp_tx = (m_left > 0) ? frame_bits[m_pos / CPB] : 1'b1;
        checkOutput("tx", 32'(tx), 32'(exp_tx));
        checkOutput("busy", 32'(busy), 32'(m_left > 0));
        checkOutput("in_ready", 32'(bus.in_ready), 32'((m_left == 0) && !r));
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00);
    endtask

    // Hold valid with a byte until the model sees it accepted, bounded in cycles.
    task automatic sendByte(input logic [7:0] d);
        int n;
        n = 0;
        acc_seen = 1'b0;
        while (!acc_seen && n < 3 * FRAME_CYC) begin
            applyStimulus(1'b0, 1'b1, d);
            n++;
        end
        checkOutput("accept", 32'(acc_seen), 32'd1);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        $display("[TB] reset and idle");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 8'h00);
        idleCycles(20);

        $display("[TB] single byte 0xA5");
        sendByte(8'hA5);
        idleCycles(FRAME_CYC + 3);

        $display("[TB] back-to-back 0x00 then 0xFF");
        sendByte(8'h00);
        sendByte(8'hFF);
        idleCycles(FRAME_CYC + 3);

        $display("[TB] reset during bit 3 of 0x3C, then 0x81");
        sendByte(8'h3C);
        idleCycles(4 * CPB);
        applyStimulus(1'b1, 1'b0, 8'h00);
        idleCycles(2);
        sendByte(8'h81);
        idleCycles(FRAME_CYC + 3);

        $display("[TB] valid pulse while busy is ignored");
        sendByte(8'hC3);
        idleCycles(10);
        applyStimulus(1'b0, 1'b1, 8'h55);
        idleCycles(FRAME_CYC + 3);
        checkOutput("frames_so_far", 32'(n_accepts), 32'd6);

        $display("[TB] reset and valid together");
        applyStimulus(1'b1, 1'b1, 8'h99);
        idleCycles(5);

`ifdef UART_TX_PARITY_EN
        $display("[TB] parity frames 0xA5 and 0x07");
        sendByte(8'hA5);
        idleCycles(FRAME_CYC + 2);
        sendByte(8'h07);
        idleCycles(FRAME_CYC + 2);
`endif

        $display("[TB] randomized traffic");
        for (int t = 0; t < 10; t++) begin
            idleCycles($urandom_range(0, 3));
            sendByte(8'($urandom));
            for (int c = 0; c < FRAME_CYC + 2; c++) begin
                applyStimulus(($urandom_range(0, 149) == 0),
                              ($urandom_range(0, 7) == 0),
                              8'($urandom));
            end
        end
        idleCycles(FRAME_CYC + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
